// File: rtl/instr_sequencer_if.sv
// Handshake and control bundle between the fetch/execute sequencer and the CPU datapath.
// master is the sequencer side; slave is the datapath/memory side.
interface instr_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic             halt_req;
  logic             instr_valid;
  logic [7:0]       instr_data;
  logic             data_valid;
  logic             instr_req;
  logic             data_req;
  logic [7:0]       ir;
  logic [7:0]       reg_read_en;
  logic [7:0]       reg_write_en;
  logic             reg_pc_read_en;
  logic             reg_pc_write_en;
  logic             pc_inc;
  logic             instr_done;
  logic             illegal_op;
  logic             bus_error;
  logic             busy;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, halt_req, instr_valid, instr_data, data_valid,
    output instr_req, data_req, ir, reg_read_en, reg_write_en, reg_pc_read_en,
           reg_pc_write_en, pc_inc, instr_done, illegal_op, bus_error, busy, retired
  );

  modport slave (
    output run, halt_req, instr_valid, instr_data, data_valid,
    input  instr_req, data_req, ir, reg_read_en, reg_write_en, reg_pc_read_en,
           reg_pc_write_en, pc_inc, instr_done, illegal_op, bus_error, busy, retired
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute controller for the 8-register accumulator CPU.
// Enables and pulses are decoded from state and IR; state, IR, wait counter and retired are registered.
module instr_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_sequencer_if.master  bus
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_ADD   = 5'h01;
  localparam logic [4:0] OP_SH    = 5'h02;
  localparam logic [4:0] OP_AND   = 5'h03;
  localparam logic [4:0] OP_OR    = 5'h04;
  localparam logic [4:0] OP_XOR   = 5'h05;
  localparam logic [4:0] OP_CPY   = 5'h06;
  localparam logic [4:0] OP_LB    = 5'h07;
  localparam logic [4:0] OP_CPYPC = 5'h08;
  localparam logic [4:0] OP_ADDI  = 5'h09;
  localparam logic [4:0] OP_SHI   = 5'h0A;
  localparam logic [4:0] OP_NOT   = 5'h0B;
  localparam logic [4:0] OP_JMP   = 5'h0C;
  localparam logic [4:0] OP_HALT  = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM_WAIT,
    S_HALTED
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        ir_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  retired_q;

  logic [4:0] opcode;
  logic [7:0] r_oh;
  logic       ir_load;
  logic       wait_clr;
  logic       wait_inc;
  logic       instr_req;
  logic       data_req;
  logic [7:0] rd_en;
  logic [7:0] wr_en;
  logic       pc_rd;
  logic       pc_wr;
  logic       pc_inc;
  logic       done;
  logic       illegal;
  logic       berr;

  assign opcode = ir_q[7:3];
  assign r_oh   = 8'h01 << ir_q[2:0];

  // Next-state and per-cycle enable decode
  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    wait_clr  = 1'b0;
    wait_inc  = 1'b0;
    instr_req = 1'b0;
    data_req  = 1'b0;
    rd_en     = 8'h00;
    wr_en     = 8'h00;
    pc_rd     = 1'b0;
    pc_wr     = 1'b0;
    pc_inc    = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    berr      = 1'b0;

    case (state)
      S_IDLE, S_HALTED: begin
        if (bus.run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        instr_req = 1'b1;
        if (bus.instr_valid) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        done = 1'b1;
        case (opcode)
          OP_NOP: ;
          OP_ADD, OP_SH, OP_AND, OP_OR, OP_XOR: begin
            rd_en = r_oh;
            wr_en = 8'h01;
          end
          OP_CPY: begin
            rd_en = 8'h01;
            wr_en = r_oh;
          end
          OP_LB: begin
            rd_en    = r_oh;
            data_req = 1'b1;
            done     = 1'b0;
            wait_clr = 1'b1;
          end
          OP_CPYPC: begin
            pc_rd = 1'b1;
            wr_en = r_oh;
          end
          OP_ADDI, OP_SHI, OP_NOT: wr_en = 8'h01;
          OP_JMP: begin
            rd_en = r_oh;
            pc_wr = 1'b1;
          end
          OP_HALT: ;
          default: illegal = 1'b1;
        endcase
        if (opcode == OP_LB)        state_nxt = S_MEM_WAIT;
        else if (opcode == OP_HALT) state_nxt = S_HALTED;
        else                        state_nxt = bus.halt_req ? S_IDLE : S_FETCH;
      end
      S_MEM_WAIT: begin
        data_req = 1'b1;
        // Returning data takes priority over a coincident timeout
        if (bus.data_valid) begin
          wr_en     = 8'h01;
          done      = 1'b1;
          state_nxt = bus.halt_req ? S_IDLE : S_FETCH;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          berr      = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, IR, LB wait counter and saturating retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ir_q      <= 8'h00;
      wait_cnt  <= '0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (ir_load) ir_q <= bus.instr_data;
      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (done && (retired_q != {CNT_W{1'b1}})) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.instr_req       = instr_req;
  assign bus.data_req        = data_req;
  assign bus.ir              = ir_q;
  assign bus.reg_read_en     = rd_en;
  assign bus.reg_write_en    = wr_en;
  assign bus.reg_pc_read_en  = pc_rd;
  assign bus.reg_pc_write_en = pc_wr;
  assign bus.pc_inc          = pc_inc;
  assign bus.instr_done      = done;
  assign bus.illegal_op      = illegal;
  assign bus.bus_error       = berr;
  assign bus.busy            = (state != S_IDLE) && (state != S_HALTED);
  assign bus.retired         = retired_q;

endmodule
